// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - ID-stage stall/flush control for load-use, taken branch and mul/div hazards
module hazard_stall_ctrl #(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 16,
  localparam int CW        = $clog2(MULDIV_LAT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rs_i,
  input  logic             id_uses_rt_i,
  input  logic             id_muldiv_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_branch_taken_i,
  output logic             pc_write_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             muldiv_start_o,
  output logic             muldiv_done_o,
  output logic             muldiv_abort_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic {RUN, MD_WAIT} state_t;

  state_t        st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          lu;

  assign lu = ex_memread_i && (ex_rd_i != 5'd0) &&
              ((id_uses_rs_i && (ex_rd_i == id_rs_i)) ||
               (id_uses_rt_i && (ex_rd_i == id_rt_i)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st  <= RUN;
      cnt <= '0;
    end else begin
      st  <= st_n;
      cnt <= cnt_n;
    end
  end

  always_comb begin
    st_n           = st;
    cnt_n          = cnt;
    pc_write_o     = 1'b1;
    ifid_stall_o   = 1'b0;
    ifid_flush_o   = 1'b0;
    idex_flush_o   = 1'b0;
    muldiv_start_o = 1'b0;
    muldiv_done_o  = 1'b0;
    muldiv_abort_o = 1'b0;
    case (st)
      RUN: begin
        if (ex_branch_taken_i) begin
          ifid_flush_o = 1'b1;
          idex_flush_o = 1'b1;
        end else if (lu) begin
          pc_write_o   = 1'b0;
          ifid_stall_o = 1'b1;
          idex_flush_o = 1'b1;
        end else if (id_muldiv_i) begin
          pc_write_o     = 1'b0;
          ifid_stall_o   = 1'b1;
          idex_flush_o   = 1'b1;
          muldiv_start_o = 1'b1;
          st_n           = MD_WAIT;
          cnt_n          = CW'(MULDIV_LAT - 1);
        end
      end
      MD_WAIT: begin
        // EX only holds bubbles here, so load-use and a new mul/div cannot arise
        if (ex_branch_taken_i) begin
          ifid_flush_o   = 1'b1;
          idex_flush_o   = 1'b1;
          muldiv_abort_o = 1'b1;
          st_n           = RUN;
          cnt_n          = '0;
        end else if (cnt > CW'(1)) begin
          pc_write_o   = 1'b0;
          ifid_stall_o = 1'b1;
          idex_flush_o = 1'b1;
          cnt_n        = cnt - CW'(1);
        end else begin
          muldiv_done_o = 1'b1;
          st_n          = RUN;
          cnt_n         = '0;
        end
      end
      default: begin
        st_n  = RUN;
        cnt_n = '0;
      end
    endcase
    if (!rst) begin
      pc_write_o     = 1'b0;
      ifid_stall_o   = 1'b0;
      ifid_flush_o   = 1'b0;
      idex_flush_o   = 1'b0;
      muldiv_start_o = 1'b0;
      muldiv_done_o  = 1'b0;
      muldiv_abort_o = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (ifid_stall_o && (stall_cnt_o != {CNT_W{1'b1}}))
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (ifid_flush_o && (flush_cnt_o != {CNT_W{1'b1}}))
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - table-driven and sequence checks for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        uses_rs, uses_rt, muldiv, memread, br;
  logic        pc_write, ifid_stall, ifid_flush, idex_flush, md_start, md_done, md_abort;
  logic [15:0] stall_cnt, flush_cnt;
  logic        s_pc_write, s_ifid_stall, s_ifid_flush, s_idex_flush, s_start, s_done, s_abort;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MULDIV_LAT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rs_i(uses_rs), .id_uses_rt_i(uses_rt),
    .id_muldiv_i(muldiv), .ex_memread_i(memread), .ex_rd_i(ex_rd), .ex_branch_taken_i(br),
    .pc_write_o(pc_write), .ifid_stall_o(ifid_stall), .ifid_flush_o(ifid_flush),
    .idex_flush_o(idex_flush), .muldiv_start_o(md_start), .muldiv_done_o(md_done),
    .muldiv_abort_o(md_abort), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  hazard_stall_ctrl #(.MULDIV_LAT(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rs_i(uses_rs), .id_uses_rt_i(uses_rt),
    .id_muldiv_i(muldiv), .ex_memread_i(memread), .ex_rd_i(ex_rd), .ex_branch_taken_i(br),
    .pc_write_o(s_pc_write), .ifid_stall_o(s_ifid_stall), .ifid_flush_o(s_ifid_flush),
    .idex_flush_o(s_idex_flush), .muldiv_start_o(s_start), .muldiv_done_o(s_done),
    .muldiv_abort_o(s_abort), .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
  );

  // {pc_write, ifid_stall, ifid_flush, idex_flush, start, done, abort}
  localparam logic [6:0] O_ZERO  = 7'b0000000;
  localparam logic [6:0] O_DEF   = 7'b1000000;
  localparam logic [6:0] O_STALL = 7'b0101000;
  localparam logic [6:0] O_FLUSH = 7'b1011000;
  localparam logic [6:0] O_START = 7'b0101100;
  localparam logic [6:0] O_DONE  = 7'b1000010;
  localparam logic [6:0] O_ABORT = 7'b1011001;

  typedef struct packed {
    logic [4:0] rs, rt, rd;
    logic       urs, urt, md, mr, br;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mk(input logic [4:0] rs, rt, rd,
                              input logic urs, urt, md, mr, b, input logic [6:0] e);
    vec_t v;
    v.rs = rs; v.rt = rt; v.rd = rd;
    v.urs = urs; v.urt = urt; v.md = md; v.mr = mr; v.br = b; v.exp = e;
    return v;
  endfunction

  function automatic logic [6:0] outs();
    return {pc_write, ifid_stall, ifid_flush, idex_flush, md_start, md_done, md_abort};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setin(input logic [4:0] rs, rt, rd, input logic urs, urt, md, mr, b);
    id_rs = rs; id_rt = rt; ex_rd = rd;
    uses_rs = urs; uses_rt = urt; muldiv = md; memread = mr; br = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs mid-cycle, check combinational outputs, then take the edge and track counters.
  task automatic step(input string name, input logic [6:0] exp);
    #2;
    chk(name, 32'(outs()), 32'(exp));
    if (exp[5]) exp_stall++;
    if (exp[4]) exp_flush++;
    tick();
  endtask

  initial begin
    tbl[0] = mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF);
    tbl[1] = mk(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, O_STALL);
    tbl[2] = mk(5'd3, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, O_STALL);
    tbl[3] = mk(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, O_DEF);
    tbl[4] = mk(5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_DEF);
    tbl[5] = mk(5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_DEF);
    tbl[6] = mk(5'd6, 5'd2, 5'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, O_DEF);
    tbl[7] = mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_FLUSH);
    tbl[8] = mk(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, O_FLUSH);
    tbl[9] = mk(5'd4, 5'd8, 5'd8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, O_FLUSH);

    rst = 1'b0;
    setin(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("reset_outs", 32'(outs()), 32'(O_ZERO));
    tick();
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset_flush_cnt", 32'(flush_cnt), 32'd0);
    #2 rst = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      setin(tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].urs, tbl[i].urt, tbl[i].md, tbl[i].mr, tbl[i].br);
      step($sformatf("vec%0d", i), tbl[i].exp);
      chk($sformatf("vec%0d_stall_cnt", i), 32'(stall_cnt), 32'(exp_stall));
      chk($sformatf("vec%0d_flush_cnt", i), 32'(flush_cnt), 32'(exp_flush));
    end

    // mul/div: 3 stall cycles, done with a load-use present, back-to-back start, then abort
    setin(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("md_c0_start", O_START);
    step("md_c1", O_STALL);
    step("md_c2", O_STALL);
    setin(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step("md_c3_done_lu_ignored", O_DONE);
    chk("md_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    setin(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("md2_start", O_START);
    step("md2_cnt3", O_STALL);
    setin(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step("md2_abort", O_ABORT);
    setin(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("after_abort_run", O_DEF);
    chk("abort_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    chk("abort_flush_cnt", 32'(flush_cnt), 32'(exp_flush));

    // asynchronous reset while waiting on mul/div
    setin(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("md3_start", O_START);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_md_outs", 32'(outs()), 32'(O_ZERO));
    chk("rst_mid_md_stall_cnt", 32'(stall_cnt), 32'd0);
    tick();
    #2 rst = 1'b1;
    setin(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_stall = 0;
    exp_flush = 0;
    step("post_rst_def", O_DEF);
    step("post_rst_no_done", O_DEF);
    chk("post_rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("post_rst_flush_cnt", 32'(flush_cnt), 32'd0);

    // 2-bit counter saturation over 5 load-use stall cycles
    setin(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step($sformatf("sat_lu%0d", i), O_STALL);
      chk($sformatf("sat_cnt%0d", i), 32'(s_stall_cnt), (i < 3) ? i : 3);
    end
    chk("sat_wide_stall_cnt", 32'(stall_cnt), 32'd5);
    chk("sat_flush_cnt", 32'(s_flush_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
